// File: rtl/gradient_wb_arbiter.sv
// Round-robin arbiter feeding the gradient writeback buffer through a one-entry output register.
// Request-to-push latency is one cycle, with no bubbles. The entry holds while wb_push_ready is low. Quiesce stops all new grants.
module gradient_wb_arbiter #(
    parameter int N_REQ = 4,
    parameter int SRC_W = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*32-1:0]       req_addr,
    input  logic signed [N_REQ*32-1:0] req_value,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      wb_push_valid,
    output logic [31:0]               wb_push_addr,
    output logic signed [31:0]        wb_push_value,
    input  logic                      wb_push_ready,
    output logic [SRC_W-1:0]          wb_push_src,
    input  logic                      quiesce_req,
    output logic                      quiesce_done,
    output logic [15:0]               push_count
);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

    state_e             state_q, state_d;
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               vld_q, vld_d;
    logic [31:0]        addr_q, addr_d;
    logic signed [31:0] value_q, value_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic [15:0]        cnt_q, cnt_d;

    logic               load_en;
    logic               grant_en;
    logic               grant;
    logic [SRC_W-1:0]   winner;

    // Lane index at offset k from base, modulo N_REQ.
    function automatic logic [SRC_W-1:0] lane_at(input logic [SRC_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return SRC_W'(s);
    endfunction

    assign load_en  = !vld_q || wb_push_ready;
    assign grant_en = (state_q == RUN) && load_en && !rst;

    always_comb begin
        grant  = 1'b0;
        winner = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant && req_valid[lane_at(rr_ptr_q, k)]) begin
                grant  = 1'b1;
                winner = lane_at(rr_ptr_q, k);
            end
        end
        if (!grant_en) grant = 1'b0;

        req_ready = '0;
        if (grant) req_ready[winner] = 1'b1;

        rr_ptr_d = grant ? lane_at(winner, 1) : rr_ptr_q;
    end

    always_comb begin
        vld_d   = vld_q;
        addr_d  = addr_q;
        value_d = value_q;
        src_d   = src_q;
        if (load_en) begin
            vld_d = grant;
            if (grant) begin
                addr_d  = req_addr[int'(winner)*32 +: 32];
                value_d = req_value[int'(winner)*32 +: 32];
                src_d   = winner;
            end
        end
        cnt_d = cnt_q + 16'(vld_q && wb_push_ready);
    end

    // DRAIN looks at the post-pop register so a final pop lands in DONE next cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (quiesce_req) state_d = DRAIN;
            DRAIN:   if (!quiesce_req) state_d = RUN;
                     else if (!vld_d) state_d = DONE;
            DONE:    if (!quiesce_req) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            rr_ptr_q <= '0;
            vld_q    <= 1'b0;
            addr_q   <= '0;
            value_q  <= '0;
            src_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            vld_q    <= vld_d;
            addr_q   <= addr_d;
            value_q  <= value_d;
            src_q    <= src_d;
            cnt_q    <= cnt_d;
        end
    end

    assign wb_push_valid = vld_q;
    assign wb_push_addr  = addr_q;
    assign wb_push_value = value_q;
    assign wb_push_src   = src_q;
    assign push_count    = cnt_q;
    assign quiesce_done  = (state_q == DONE);

endmodule

// File: tb/tb_gradient_wb_arbiter.sv
// Bench for gradient_wb_arbiter: directed stimulus, per-cycle model comparison, literal spot checks.
module tb_gradient_wb_arbiter;
    localparam int N  = 4;
    localparam int SW = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [N-1:0]           req_valid = '0;
    logic [N*32-1:0]        req_addr;
    logic signed [N*32-1:0] req_value;
    logic [N-1:0]           req_ready;
    logic                   wb_push_valid;
    logic [31:0]            wb_push_addr;
    logic signed [31:0]     wb_push_value;
    logic                   wb_push_ready = 1'b0;
    logic [SW-1:0]          wb_push_src;
    logic                   quiesce_req = 1'b0;
    logic                   quiesce_done;
    logic [15:0]            push_count;

    gradient_wb_arbiter #(.N_REQ(N), .SRC_W(SW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_value(req_value), .req_ready(req_ready),
        .wb_push_valid(wb_push_valid), .wb_push_addr(wb_push_addr), .wb_push_value(wb_push_value),
        .wb_push_ready(wb_push_ready), .wb_push_src(wb_push_src),
        .quiesce_req(quiesce_req), .quiesce_done(quiesce_done), .push_count(push_count)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: pending entry, next lane to favour, quiesce phase, push tally.
    bit          m_vld;
    logic [31:0] m_addr;
    logic [31:0] m_val;
    int          m_src;
    int          m_rr;
    int          m_cnt;
    bit          m_draining;
    bit          m_parked;

    always @(negedge clk) begin
        int       win;
        bit       can_load;
        logic [N-1:0] er;
        if (rst) begin
            m_vld = 0; m_addr = 0; m_val = 0; m_src = 0; m_rr = 0; m_cnt = 0;
            m_draining = 0; m_parked = 0;
            chk("model_rst_ready", 32'(req_ready), 0);
            chk("model_rst_valid", 32'(wb_push_valid), 0);
            chk("model_rst_count", 32'(push_count), 0);
            chk("model_rst_done", 32'(quiesce_done), 0);
        end else begin
            chk("model_valid", 32'(wb_push_valid), 32'(m_vld));
            if (m_vld) begin
                chk("model_addr", wb_push_addr, m_addr);
                chk("model_value", wb_push_value, m_val);
                chk("model_src", 32'(wb_push_src), 32'(m_src));
            end
            chk("model_count", 32'(push_count), 32'(m_cnt));
            chk("model_done", 32'(quiesce_done), 32'(m_parked));

            can_load = !m_vld || wb_push_ready;
            win = -1;
            if (!m_draining && !m_parked && can_load)
                for (int k = 0; k < N; k++)
                    if (win < 0 && req_valid[(m_rr + k) % N]) win = (m_rr + k) % N;
            er = '0;
            if (win >= 0) er[win] = 1'b1;
            chk("model_req_ready", 32'(req_ready), 32'(er));

            if (m_vld && wb_push_ready) m_cnt = (m_cnt + 1) % 65536;
            if (can_load) begin
                m_vld = (win >= 0);
                if (win >= 0) begin
                    m_addr = req_addr[win*32 +: 32];
                    m_val  = req_value[win*32 +: 32];
                    m_src  = win;
                    m_rr   = (win + 1) % N;
                end
            end
            if (m_parked) begin
                if (!quiesce_req) m_parked = 0;
            end else if (m_draining) begin
                if (!quiesce_req) m_draining = 0;
                else if (!m_vld) begin m_draining = 0; m_parked = 1; end
            end else if (quiesce_req) begin
                m_draining = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            req_addr[i*32 +: 32]  = 32'h100 * (i + 1);
            req_value[i*32 +: 32] = 32'(i + 1);
        end
        req_valid = 4'hF;
        tick(); tick();
        chk("rst_req_ready_gated", 32'(req_ready), 0);
        chk("rst_valid", 32'(wb_push_valid), 0);
        chk("rst_addr", wb_push_addr, 0);
        chk("rst_count", 32'(push_count), 0);

        // Reset mid-operation with seven pushes done and an entry held
        rst = 1'b0; req_valid = 4'b0001; wb_push_ready = 1'b1;
        repeat (8) tick();
        chk("pre_rst_count", 32'(push_count), 7);
        chk("pre_rst_valid", 32'(wb_push_valid), 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(wb_push_valid), 0);
        chk("async_rst_count", 32'(push_count), 0);
        chk("async_rst_ready", 32'(req_ready), 0);
        tick();
        rst = 1'b0; req_valid = 4'hF;
        #1 chk("post_rst_first_lane0", 32'(req_ready), 32'b0001);
        tick();
        chk("post_rst_src", 32'(wb_push_src), 0);
        rst = 1'b1; req_valid = '0;
        tick();
        rst = 1'b0;

        // Round robin with all lanes valid, full throughput
        req_valid = 4'hF;
        #1 chk("rr_first_ready", 32'(req_ready), 32'b0001);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_src", 32'(wb_push_src), 32'(k % 4));
            chk("rr_addr", wb_push_addr, 32'h100 * (k % 4 + 1));
        end
        req_valid = '0;
        tick();
        chk("rr_count8", 32'(push_count), 8);
        chk("rr_drained", 32'(wb_push_valid), 0);

        // Single lane 2 with a negative value
        req_addr[2*32 +: 32]  = 32'h40;
        req_value[2*32 +: 32] = -32'sd5;
        req_valid = 4'b0100;
        #1 chk("single_ready", 32'(req_ready), 32'b0100);
        tick();
        chk("single_valid", 32'(wb_push_valid), 1);
        chk("single_addr", wb_push_addr, 32'h40);
        chk("single_value", wb_push_value, 32'hFFFF_FFFB);
        chk("single_src", 32'(wb_push_src), 2);
        req_valid = '0;
        tick();

        // Backpressure: entry held stable, then pop and reload in one cycle
        wb_push_ready = 1'b0; req_valid = 4'b1001;
        #1 chk("stall_ptr_after_lane2", 32'(req_ready), 32'b1000);
        tick();
        req_valid = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_no_ready", 32'(req_ready), 0);
            chk("stall_src", 32'(wb_push_src), 3);
            chk("stall_addr", wb_push_addr, 32'h400);
            tick();
        end
        wb_push_ready = 1'b1;
        #1 chk("unstall_ready", 32'(req_ready), 32'b0001);
        tick();
        chk("unstall_valid", 32'(wb_push_valid), 1);
        chk("unstall_src", 32'(wb_push_src), 0);
        req_valid = '0;
        tick();
        chk("unstall_count", 32'(push_count), 11);

        // Quiesce while an entry is held under backpressure
        wb_push_ready = 1'b0; req_valid = 4'b0010;
        tick();
        quiesce_req = 1'b1; req_valid = 4'hF;
        #1 chk("q_gate_same_cycle", 32'(req_ready), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("q_drain_ready", 32'(req_ready), 0);
            chk("q_drain_done", 32'(quiesce_done), 0);
            chk("q_drain_valid", 32'(wb_push_valid), 1);
        end
        wb_push_ready = 1'b1;
        #1 chk("q_pop_ready", 32'(req_ready), 0);
        tick();
        chk("q_done", 32'(quiesce_done), 1);
        chk("q_empty", 32'(wb_push_valid), 0);
        chk("q_count", 32'(push_count), 12);
        quiesce_req = 1'b0;
        #1 chk("q_done_no_grant", 32'(req_ready), 0);
        tick();
        chk("q_resume_done", 32'(quiesce_done), 0);
        chk("q_resume_ptr", 32'(req_ready), 32'b0100);
        tick();
        chk("q_resume_src", 32'(wb_push_src), 2);
        req_valid = '0;
        tick();

        // Quiesce with an empty register: done two cycles after the request
        quiesce_req = 1'b1;
        tick();
        chk("qe_done_c1", 32'(quiesce_done), 0);
        tick();
        chk("qe_done_c2", 32'(quiesce_done), 1);
        quiesce_req = 1'b0;
        tick();
        chk("qe_release", 32'(quiesce_done), 0);

        // Counter wrap: count is 13 here, 65523 ticks give 65522 pops
        req_valid = 4'hF;
        repeat (65523) tick();
        chk("wrap_max", 32'(push_count), 65535);
        tick();
        chk("wrap_zero", 32'(push_count), 0);
        tick();
        chk("wrap_one", 32'(push_count), 1);
        req_valid = '0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
